// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive packer.
package uart_pkg;

    localparam int unsigned MAX_WORD_BITS = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    function automatic int unsigned packet_width(input int unsigned n_words,
                                                 input int unsigned bits_per_word);
        return n_words * bits_per_word;
    endfunction

    // Expected parity bit for a zero-extended data word.
    function automatic logic parity_bit(input logic [MAX_WORD_BITS-1:0] data,
                                        input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_word.sv
// Single-word UART receiver: rx synchroniser, bit-timing FSM and LSB-first shifter.
// Status outputs are combinational strobes asserted in the cycle of the final stop sample.
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PULSE = 4,
    parameter int unsigned BITS_PER_WORD    = 8,
    parameter int unsigned PARITY_EN        = 0,
    parameter int unsigned PARITY_ODD       = 0,
    parameter int unsigned STOP_BITS        = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    output logic [BITS_PER_WORD-1:0] word,
    output logic                     word_valid_c,
    output logic                     err_frame_c,
    output logic                     err_parity_c,
    output logic                     active_c
);

    localparam int unsigned CNT_W = $clog2(CLOCKS_PER_PULSE);
    localparam int unsigned BIT_W = $clog2(BITS_PER_WORD);
    localparam int unsigned HALF  = CLOCKS_PER_PULSE / 2 - 1;

    state_t                   state, state_next;
    logic                     rx_meta, rx_s;
    logic [CNT_W-1:0]         cnt, cnt_next;
    logic [BIT_W-1:0]         bit_idx, bit_next;
    logic [BITS_PER_WORD-1:0] word_next;
    logic                     par_bit, par_next;
    logic                     stop_idx, stop_next;
    logic                     frame_bad, frame_bad_next;
    logic                     frame_err, parity_err;

    // Synchroniser idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            word      <= '0;
            par_bit   <= 1'b0;
            stop_idx  <= 1'b0;
            frame_bad <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_next;
            word      <= word_next;
            par_bit   <= par_next;
            stop_idx  <= stop_next;
            frame_bad <= frame_bad_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        bit_next       = bit_idx;
        word_next      = word;
        par_next       = par_bit;
        stop_next      = stop_idx;
        frame_bad_next = frame_bad;
        word_valid_c   = 1'b0;
        err_frame_c    = 1'b0;
        err_parity_c   = 1'b0;
        frame_err      = frame_bad | ~rx_s;
        parity_err     = (PARITY_EN != 0) &&
                         (par_bit != parity_bit(MAX_WORD_BITS'(word), 1'(PARITY_ODD)));

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) state_next = START;
            end
            START: begin
                if (cnt == CNT_W'(HALF)) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_s ? IDLE : DATA;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_W'(CLOCKS_PER_PULSE - 1)) begin
                    cnt_next  = '0;
                    word_next = {rx_s, word[BITS_PER_WORD-1:1]};
                    bit_next  = bit_idx + BIT_W'(1);
                    if (bit_idx == BIT_W'(BITS_PER_WORD - 1)) begin
                        stop_next      = 1'b0;
                        frame_bad_next = 1'b0;
                        state_next     = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            PARITY: begin
                if (cnt == CNT_W'(CLOCKS_PER_PULSE - 1)) begin
                    cnt_next   = '0;
                    par_next   = rx_s;
                    state_next = STOP;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_W'(CLOCKS_PER_PULSE - 1)) begin
                    cnt_next = '0;
                    // Leaving at mid stop bit keeps a back-to-back start bit visible.
                    if (stop_idx == 1'(STOP_BITS - 1)) begin
                        err_frame_c  = frame_err;
                        err_parity_c = parity_err;
                        word_valid_c = ~frame_err & ~parity_err;
                        state_next   = IDLE;
                    end else begin
                        stop_next      = 1'b1;
                        frame_bad_next = frame_err;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        active_c = (state_next != IDLE);
    end

endmodule

// File: rtl/uart_rx_packer.sv
// Packs N_WORDS received UART words into one packet on a valid/ready output,
// with inter-word timeout and overflow reporting.
module uart_rx_packer
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PULSE = 4,
    parameter int unsigned BITS_PER_WORD    = 8,
    parameter int unsigned N_WORDS          = 10,
    parameter int unsigned PARITY_EN        = 0,
    parameter int unsigned PARITY_ODD       = 0,
    parameter int unsigned STOP_BITS        = 1,
    parameter int unsigned TIMEOUT_PULSES   = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rx,
    output logic [N_WORDS*BITS_PER_WORD-1:0]   m_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic                               err_frame,
    output logic                               err_parity,
    output logic                               err_timeout,
    output logic                               err_overflow,
    output logic                               busy
);

    localparam int unsigned PKT_W    = packet_width(N_WORDS, BITS_PER_WORD);
    localparam int unsigned IDX_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int unsigned TO_LIMIT = (TIMEOUT_PULSES == 0) ? 1 : TIMEOUT_PULSES * CLOCKS_PER_PULSE;
    localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

    logic [BITS_PER_WORD-1:0] word;
    logic                     word_valid_c, err_frame_c, err_parity_c, active_c;

    logic [PKT_W-1:0] asm_q, asm_next, m_data_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [TO_W-1:0]  tcnt, tcnt_next;
    logic             m_valid_next, busy_next;
    logic             err_frame_next, err_parity_next, err_timeout_next, err_overflow_next;

    uart_rx_word #(
        .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE),
        .BITS_PER_WORD    (BITS_PER_WORD),
        .PARITY_EN        (PARITY_EN),
        .PARITY_ODD       (PARITY_ODD),
        .STOP_BITS        (STOP_BITS)
    ) u_word (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .word         (word),
        .word_valid_c (word_valid_c),
        .err_frame_c  (err_frame_c),
        .err_parity_c (err_parity_c),
        .active_c     (active_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q        <= '0;
            idx          <= '0;
            tcnt         <= '0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            busy         <= 1'b0;
            err_frame    <= 1'b0;
            err_parity   <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            asm_q        <= asm_next;
            idx          <= idx_next;
            tcnt         <= tcnt_next;
            m_data       <= m_data_next;
            m_valid      <= m_valid_next;
            busy         <= busy_next;
            err_frame    <= err_frame_next;
            err_parity   <= err_parity_next;
            err_timeout  <= err_timeout_next;
            err_overflow <= err_overflow_next;
        end
    end

    always_comb begin
        asm_next          = asm_q;
        idx_next          = idx;
        tcnt_next         = '0;
        m_data_next       = m_data;
        m_valid_next      = m_valid & ~m_ready;
        err_frame_next    = 1'b0;
        err_parity_next   = 1'b0;
        err_timeout_next  = 1'b0;
        err_overflow_next = 1'b0;

        if (err_frame_c || err_parity_c) begin
            // Bad word poisons the whole partial packet.
            err_frame_next  = err_frame_c;
            err_parity_next = err_parity_c;
            idx_next        = '0;
        end else if (word_valid_c) begin
            for (int i = 0; i < N_WORDS; i++) begin
                if (idx == IDX_W'(i)) asm_next[i*BITS_PER_WORD +: BITS_PER_WORD] = word;
            end
            if (idx == IDX_W'(N_WORDS - 1)) begin
                idx_next = '0;
                if (!m_valid || m_ready) begin
                    m_data_next  = asm_next;
                    m_valid_next = 1'b1;
                end else begin
                    err_overflow_next = 1'b1;
                end
            end else begin
                idx_next = idx + IDX_W'(1);
            end
        end else if ((TIMEOUT_PULSES != 0) && !active_c && (idx != '0)) begin
            // Idle gap inside a packet; any start bit clears the count.
            if (tcnt == TO_W'(TO_LIMIT - 1)) begin
                idx_next         = '0;
                err_timeout_next = 1'b1;
            end else begin
                tcnt_next = tcnt + TO_W'(1);
            end
        end

        busy_next = active_c | (idx_next != '0);
    end

endmodule

// File: tb/tb_uart_rx_packer.sv
// Scoreboard bench for uart_rx_packer: a default 8N1 instance and an even-parity instance.
module tb_uart_rx_packer;

    localparam int unsigned CPP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1, rx_p = 1'b1;
    logic        m_ready = 1'b1, m_ready_p = 1'b1;
    logic [79:0] m_data, m_data_p;
    logic        m_valid, m_valid_p;
    logic        err_frame, err_parity, err_timeout, err_overflow, busy;
    logic        err_frame_p, err_parity_p, err_timeout_p, err_overflow_p, busy_p;

    int total = 0;
    int bad   = 0;
    int cf = 0, cp = 0, ct = 0, co = 0;
    int cfp = 0, cpp = 0, ctp = 0, cop = 0;

    logic [79:0] exp_q[$];
    logic [79:0] exp_qp[$];
    logic [79:0] exp0_v, exp1_v;

    always #5 clk = ~clk;

    uart_rx_packer #(
        .CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .N_WORDS(10), .PARITY_EN(0),
        .PARITY_ODD(0), .STOP_BITS(1), .TIMEOUT_PULSES(32)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .err_frame(err_frame), .err_parity(err_parity), .err_timeout(err_timeout),
        .err_overflow(err_overflow), .busy(busy)
    );

    uart_rx_packer #(
        .CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .N_WORDS(10), .PARITY_EN(1),
        .PARITY_ODD(0), .STOP_BITS(1), .TIMEOUT_PULSES(32)
    ) dut_p (
        .clk(clk), .rst(rst), .rx(rx_p), .m_data(m_data_p), .m_valid(m_valid_p), .m_ready(m_ready_p),
        .err_frame(err_frame_p), .err_parity(err_parity_p), .err_timeout(err_timeout_p),
        .err_overflow(err_overflow_p), .busy(busy_p)
    );

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Packet monitor and error-pulse bookkeeping, default instance.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pkt0 unexpected: got %h want none", m_data);
            end else begin
                exp0_v = exp_q.pop_front();
                check("pkt0", m_data, exp0_v);
            end
        end
        if (err_frame)    cf++;
        if (err_parity)   cp++;
        if (err_timeout)  ct++;
        if (err_overflow) co++;
        if (err_frame || err_parity || err_timeout || err_overflow)
            check("err0_exclusive",
                  80'(int'(err_timeout) + int'(err_overflow) + int'(err_frame | err_parity)), 80'd1);
    end

    // Packet monitor and error-pulse bookkeeping, parity instance.
    always @(negedge clk) begin
        if (!rst && m_valid_p && m_ready_p) begin
            if (exp_qp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pkt1 unexpected: got %h want none", m_data_p);
            end else begin
                exp1_v = exp_qp.pop_front();
                check("pkt1", m_data_p, exp1_v);
            end
        end
        if (err_frame_p)    cfp++;
        if (err_parity_p)   cpp++;
        if (err_timeout_p)  ctp++;
        if (err_overflow_p) cop++;
        if (err_frame_p || err_parity_p || err_timeout_p || err_overflow_p)
            check("err1_exclusive",
                  80'(int'(err_timeout_p) + int'(err_overflow_p) + int'(err_frame_p | err_parity_p)), 80'd1);
    end

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx_p = v;
        else     rx   = v;
    endtask

    task automatic bit_time();
        repeat (CPP) @(negedge clk);
    endtask

    // One frame; sel=1 targets the parity instance and appends a parity bit.
    task automatic send_word(input bit sel, input logic [7:0] d, input logic stop_v, input logic par_flip);
        set_line(sel, 1'b0);
        bit_time();
        for (int i = 0; i < 8; i++) begin
            set_line(sel, d[i]);
            bit_time();
        end
        if (sel) begin
            set_line(sel, (^d) ^ par_flip);
            bit_time();
        end
        set_line(sel, stop_v);
        bit_time();
        set_line(sel, 1'b1);
    endtask

    task automatic gap();
        repeat ($urandom_range(1, 20)) @(negedge clk);
    endtask

    task automatic send_packet(input bit sel, input logic [79:0] pkt);
        for (int i = 0; i < 10; i++) begin
            send_word(sel, pkt[i*8 +: 8], 1'b1, 1'b0);
            gap();
        end
    endtask

    task automatic wait_drain(input bit sel, input string name);
        int n;
        n = 0;
        while (((sel ? exp_qp.size() : exp_q.size()) != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 400) begin
            bad++;
            $display("FAIL %s drain: pending=%0d want 0", name, sel ? exp_qp.size() : exp_q.size());
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_m_data", m_data, 80'h0);
        check("rst_m_valid", 80'(m_valid), 80'h0);
        check("rst_busy", 80'(busy), 80'h0);
        check("rst_errs", 80'({err_frame, err_parity, err_timeout, err_overflow}), 80'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic packet, first word in the LSBs.
        exp_q.push_back(80'h99887766554433221100);
        send_packet(1'b0, 80'h99887766554433221100);
        wait_drain(1'b0, "basic");
        check("basic_busy", 80'(busy), 80'h0);

        // Even parity: 0x07 needs parity 1, send 0.
        send_word(1'b1, 8'h07, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        check("par_err_count", 80'(cpp), 80'd1);
        check("par_frame_count", 80'(cfp), 80'd0);
        exp_qp.push_back(80'h19181716151413121110);
        send_packet(1'b1, 80'h19181716151413121110);
        wait_drain(1'b1, "parity");

        // Two-clock glitch: false start, no error.
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_busy", 80'(busy), 80'h0);
        check("glitch_errs", 80'(cf + cp + ct + co), 80'd0);

        // Timeout discards a 3-word partial packet.
        send_word(1'b0, 8'h60, 1'b1, 1'b0); gap();
        send_word(1'b0, 8'h61, 1'b1, 1'b0); gap();
        send_word(1'b0, 8'h62, 1'b1, 1'b0);
        repeat (32 * CPP + 4) @(negedge clk);
        check("timeout_count", 80'(ct), 80'd1);
        check("timeout_busy", 80'(busy), 80'h0);
        exp_q.push_back(80'h79787776757473727170);
        send_packet(1'b0, 80'h79787776757473727170);
        wait_drain(1'b0, "timeout");

        // Overflow: first packet held, second dropped.
        m_ready = 1'b0;
        exp_q.push_back(80'hA9A8A7A6A5A4A3A2A1A0);
        send_packet(1'b0, 80'hA9A8A7A6A5A4A3A2A1A0);
        send_packet(1'b0, 80'hB9B8B7B6B5B4B3B2B1B0);
        repeat (4) @(negedge clk);
        check("ovf_count", 80'(co), 80'd1);
        check("ovf_valid_held", 80'(m_valid), 80'h1);
        check("ovf_data_held", m_data, 80'hA9A8A7A6A5A4A3A2A1A0);
        m_ready = 1'b1;
        wait_drain(1'b0, "overflow");
        repeat (3) @(negedge clk);
        check("ovf_valid_drop", 80'(m_valid), 80'h0);

        // Bad stop bit on word 2 discards words 0 and 1.
        send_word(1'b0, 8'h40, 1'b1, 1'b0); gap();
        send_word(1'b0, 8'h41, 1'b1, 1'b0); gap();
        send_word(1'b0, 8'h42, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("frame_count", 80'(cf), 80'd1);
        check("frame_busy", 80'(busy), 80'h0);
        exp_q.push_back(80'h59585756555453525150);
        send_packet(1'b0, 80'h59585756555453525150);
        wait_drain(1'b0, "frame");

        // Reset in the middle of a data bit of word 5.
        for (int i = 0; i < 5; i++) begin
            send_word(1'b0, 8'h20 + 8'(i), 1'b1, 1'b0);
            gap();
        end
        rx = 1'b0;
        bit_time();
        rx = 1'b1; bit_time();
        rx = 1'b0; bit_time();
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", 80'(busy), 80'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_m_data", m_data, 80'h0);
        check("mid_rst_valid_busy", 80'({m_valid, busy}), 80'h0);
        check("mid_rst_errs", 80'({err_frame, err_parity, err_timeout, err_overflow}), 80'h0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        exp_q.push_back(80'h39383736353433323130);
        send_packet(1'b0, 80'h39383736353433323130);
        wait_drain(1'b0, "post_reset");

        repeat (20) @(negedge clk);
        check("final_frame0", 80'(cf), 80'd1);
        check("final_parity0", 80'(cp), 80'd0);
        check("final_timeout0", 80'(ct), 80'd1);
        check("final_overflow0", 80'(co), 80'd1);
        check("final_errs1", 80'({cfp[7:0], cpp[7:0], ctp[7:0], cop[7:0]}), 80'h00010000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_packer.md
Name: uart_rx_packer

Overview:
- Parametrised UART receive front end for the tinytapout MVM system; successor to the fixed 8N1 receive path feeding the matrix-vector core.
- Deserialises N_WORDS UART words into one wide packet bus and presents it on a valid/ready handshake.
- Adds configurable parity, stop-bit count, framing/parity error detection, inter-word timeout and packet overflow flagging.
- Sits between the ui_in[0] rx pin and the MVM K/X input bus.

Parameters:
- CLOCKS_PER_PULSE, 4, clocks per UART bit; must be ≥ 4 and even.
- BITS_PER_WORD, 8, data bits per word (5..9).
- N_WORDS, 10, words per packet; packet width N_WORDS*BITS_PER_WORD.
- PARITY_EN, 0, 1 = one parity bit follows the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0).
- STOP_BITS, 1, number of stop bits checked (1 or 2).
- TIMEOUT_PULSES, 32, idle bit-times allowed between words of one packet; 0 disables the timeout.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- rx, input, 1, UART line, idle high, asynchronous to clk.
- m_data, output, N_WORDS*BITS_PER_WORD, packet; word i at [i*BITS_PER_WORD +: BITS_PER_WORD], first received word in the LSBs.
- m_valid, output, 1, packet available.
- m_ready, input, 1, consumer accepts the packet.
- err_frame, output, 1, one-cycle pulse: stop bit sampled low.
- err_parity, output, 1, one-cycle pulse: parity mismatch.
- err_timeout, output, 1, one-cycle pulse: partial packet discarded on timeout.
- err_overflow, output, 1, one-cycle pulse: completed packet dropped because the output was full.
- busy, output, 1, high when the FSM is not in IDLE or the word index is non-zero.

Behaviour:
- Reset values: m_data=0, m_valid=0, all err_* signals 0, busy=0. Synchroniser flops reset to 1, FSM goes to IDLE, word index and all counters clear.
- Reset mid-frame aborts the frame immediately and discards the partial packet.
- rx passes through a 2-flop synchroniser. All sampling uses rx_s, the synchroniser output.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when rx_s is 0; the bit counter clears.
- START: at count CLOCKS_PER_PULSE/2-1 (mid-bit), sample rx_s.
  - rx_s=1: false start; return to IDLE with no error.
  - rx_s=0: go to DATA.
- DATA: sample every CLOCKS_PER_PULSE clocks, LSB first, BITS_PER_WORD samples. Then go to PARITY if PARITY_EN=1, else STOP.
- PARITY: one sample. Expected bit = XOR of the data bits, XOR PARITY_ODD.
- STOP: take STOP_BITS samples.
  - Any sample of 0 → pulse err_frame.
  - A parity mismatch pulses err_parity in the same cycle as the last stop sample.
  - On either error: discard the word and the whole partial packet, clear the word index, go to IDLE. If the line is still 0, IDLE re-arms on the next low sample.
- Good word: written into the assembly register at the current word index, the index increments, go to IDLE.
  - Return is at mid stop bit, so a back-to-back start bit is detected.
- Packet completion: index reaches N_WORDS after a good word; the index wraps to 0.
  - Output empty, or m_valid && m_ready in the same cycle: the assembly is copied into m_data and m_valid=1 on the next cycle. Latency is 1 clock after the final stop sample.
  - Otherwise: the packet is dropped, err_overflow pulses, and m_data/m_valid are unchanged.
- Handshake: m_data is stable while m_valid=1. m_valid falls on the cycle after m_valid && m_ready unless a new packet loads that same cycle.
- Timeout: counts clocks while in IDLE with index ≠ 0. At TIMEOUT_PULSES*CLOCKS_PER_PULSE, clear the index and pulse err_timeout. The counter clears on any start bit.
- Error pulses are never asserted simultaneously except err_parity together with err_frame.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - a localparam function for packet width;
  - a parity helper function.
- Sub-module uart_rx_word: synchroniser, FSM and single-word shift register. Outputs word, word_valid, err_frame and err_parity.
- The top level does packing, timeout and the output register.

Test Plan:
- Defaults, 10 words 0x00,0x11,…,0x99 with random 1–20 clk gaps → one m_valid with m_data=80'h99887766554433221100; m_ready held high.
- PARITY_EN=1, PARITY_ODD=0, word 0x07 sent with parity bit 0 → err_parity pulses once, no m_valid. The next 10 good words produce a packet.
- 2-clock low glitch on idle rx → no state advance past START, no error, busy returns to 0.
- 3 words then silence for 32*4+4 clocks → err_timeout pulses. The following 10 words yield a packet containing only those words.
- m_ready=0, two full packets sent → the first is held, err_overflow pulses at the second completion, and m_data still equals the first packet. Raising m_ready then drops m_valid.
- rst asserted mid DATA bit of word 5 → all outputs 0 immediately. A fresh 10-word packet after release is received correctly.
- Stop bit forced 0 on word 2 → err_frame pulse and the partial packet is discarded.
